// File: rtl/jtag_dmi_responder.sv
// JTAG TAP with IDCODE/DTMCS/DMI/BYPASS data registers and a valid/ready DMI
// bridge. All JTAG pins are oversampled in the clk_i domain.

package jtag_dmi_responder_pkg;

  localparam int unsigned AddrW = 7;
  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 2;
  localparam int unsigned IrW   = 5;
  localparam int unsigned DrW   = AddrW + DataW + OpW;
  localparam int unsigned PinW  = 4;

  localparam logic [IrW-1:0] IrIdcode = 5'h01;
  localparam logic [IrW-1:0] IrDtmcs  = 5'h10;
  localparam logic [IrW-1:0] IrDmi    = 5'h11;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [OpW-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [OpW-1:0]   resp;
  } dmi_rsp_t;

  typedef enum logic [3:0] {
    TapTlr,
    TapIdle,
    TapSelDr,
    TapCapDr,
    TapShiftDr,
    TapExit1Dr,
    TapPauseDr,
    TapExit2Dr,
    TapUpdDr,
    TapSelIr,
    TapCapIr,
    TapShiftIr,
    TapExit1Ir,
    TapPauseIr,
    TapExit2Ir,
    TapUpdIr
  } tap_state_e;

endpackage

module jtag_dmi_responder
  import jtag_dmi_responder_pkg::*;
#(
  parameter logic [31:0] IdCode     = 32'h1C5E_5DB3,
  parameter int unsigned SyncStages = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     jtag_tck_i,
  input  logic     jtag_tms_i,
  input  logic     jtag_tdi_i,
  input  logic     jtag_trst_ni,
  output logic     jtag_tdo_o,
  output logic     jtag_tdo_oe_o,
  output logic     dmi_req_valid_o,
  input  logic     dmi_req_ready_i,
  output dmi_req_t dmi_req_o,
  input  logic     dmi_rsp_valid_i,
  output logic     dmi_rsp_ready_o,
  input  dmi_rsp_t dmi_rsp_i
);

  // Synchronizer chains, one bit per pin: {tck, tms, tdi, trst_n}
  logic [PinW-1:0] sync_q [SyncStages];
  logic [PinW-1:0] sync_d [SyncStages];

  logic tck_prev_q, tck_prev_d;
  logic tck_s, tms_s, tdi_s, trst_s;
  logic tck_rise, tck_fall;

  tap_state_e       state_q, state_d;
  logic [IrW-1:0]   ir_q, ir_d;
  logic [IrW-1:0]   ir_shift_q, ir_shift_d;
  logic [DrW-1:0]   dr_q, dr_d;
  logic [1:0]       dmistat_q, dmistat_d;
  logic [AddrW-1:0] last_addr_q, last_addr_d;
  logic [DataW-1:0] last_data_q, last_data_d;
  dmi_req_t         req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic             rsp_pending_q, rsp_pending_d;
  logic             tdo_q, tdo_d;
  logic             tdo_oe_q, tdo_oe_d;

  logic [31:0]      dtmcs_cap;
  logic [DrW-1:0]   dr_capture;
  logic [DrW-1:0]   dr_shifted;

  // Synchronizer next values: shift each pin one stage deeper
  always_comb begin
    sync_d[0] = {jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni};
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    tck_prev_d = tck_s;
  end

  assign tck_s    = sync_q[SyncStages-1][3];
  assign tms_s    = sync_q[SyncStages-1][2];
  assign tdi_s    = sync_q[SyncStages-1][1];
  assign trst_s   = sync_q[SyncStages-1][0];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  // TAP next state, advanced on each synced TCK rising edge
  always_comb begin
    state_d = state_q;
    if (!trst_s) begin
      state_d = TapTlr;
    end else if (tck_rise) begin
      case (state_q)
        TapTlr:     state_d = tms_s ? TapTlr     : TapIdle;
        TapIdle:    state_d = tms_s ? TapSelDr   : TapIdle;
        TapSelDr:   state_d = tms_s ? TapSelIr   : TapCapDr;
        TapCapDr:   state_d = tms_s ? TapExit1Dr : TapShiftDr;
        TapShiftDr: state_d = tms_s ? TapExit1Dr : TapShiftDr;
        TapExit1Dr: state_d = tms_s ? TapUpdDr   : TapPauseDr;
        TapPauseDr: state_d = tms_s ? TapExit2Dr : TapPauseDr;
        TapExit2Dr: state_d = tms_s ? TapUpdDr   : TapShiftDr;
        TapUpdDr:   state_d = tms_s ? TapSelDr   : TapIdle;
        TapSelIr:   state_d = tms_s ? TapTlr     : TapCapIr;
        TapCapIr:   state_d = tms_s ? TapExit1Ir : TapShiftIr;
        TapShiftIr: state_d = tms_s ? TapExit1Ir : TapShiftIr;
        TapExit1Ir: state_d = tms_s ? TapUpdIr   : TapPauseIr;
        TapPauseIr: state_d = tms_s ? TapExit2Ir : TapPauseIr;
        TapExit2Ir: state_d = tms_s ? TapUpdIr   : TapShiftIr;
        TapUpdIr:   state_d = tms_s ? TapSelDr   : TapIdle;
        default:    state_d = TapTlr;
      endcase
    end
  end

  // Capture and shift values of the data register selected by IR
  always_comb begin
    dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'd7, 4'd1};
    case (ir_q)
      IrIdcode: begin
        dr_capture = DrW'({IdCode[31:1], 1'b1});
        dr_shifted = DrW'({tdi_s, dr_q[31:1]});
      end
      IrDtmcs: begin
        dr_capture = DrW'(dtmcs_cap);
        dr_shifted = DrW'({tdi_s, dr_q[31:1]});
      end
      IrDmi: begin
        dr_capture = {last_addr_q, last_data_q, dmistat_q};
        dr_shifted = {tdi_s, dr_q[DrW-1:1]};
      end
      default: begin
        dr_capture = '0;
        dr_shifted = DrW'(tdi_s);
      end
    endcase
  end

  // TAP register actions, DMI request/response tracking and TDO
  always_comb begin
    ir_d          = ir_q;
    ir_shift_d    = ir_shift_q;
    dr_d          = dr_q;
    dmistat_d     = dmistat_q;
    last_addr_d   = last_addr_q;
    last_data_d   = last_data_q;
    req_d         = req_q;
    req_valid_d   = req_valid_q;
    rsp_pending_d = rsp_pending_q;
    tdo_d         = tdo_q;
    tdo_oe_d      = (state_d == TapShiftIr) || (state_d == TapShiftDr);

    // Request accepted: now waiting for the response
    if (req_valid_q && dmi_req_ready_i) begin
      req_valid_d   = 1'b0;
      rsp_pending_d = 1'b1;
    end

    // Response accepted: keep data, flag an error only if none is pending
    if (rsp_pending_q && dmi_rsp_valid_i) begin
      last_data_d   = dmi_rsp_i.data;
      rsp_pending_d = 1'b0;
      if ((dmi_rsp_i.resp != 2'd0) && (dmistat_q == 2'd0)) begin
        dmistat_d = 2'd2;
      end
    end

    if (tck_rise) begin
      case (state_q)
        TapCapIr:   ir_shift_d = 5'b00001;
        TapShiftIr: ir_shift_d = {tdi_s, ir_shift_q[IrW-1:1]};
        TapCapDr:   dr_d = dr_capture;
        TapShiftDr: dr_d = dr_shifted;
        default: ;
      endcase
    end

    // Updates and TDO follow the TCK falling edge, as on a real TAP
    if (tck_fall) begin
      tdo_d = (state_q == TapShiftIr) ? ir_shift_q[0] : dr_q[0];
      if (state_q == TapUpdIr) begin
        ir_d = ir_shift_q;
      end
      if (state_q == TapUpdDr) begin
        if (ir_q == IrDtmcs) begin
          if (dr_q[17]) begin
            dmistat_d     = 2'd0;
            req_valid_d   = 1'b0;
            rsp_pending_d = 1'b0;
          end else if (dr_q[16]) begin
            dmistat_d = 2'd0;
          end
        end else if (ir_q == IrDmi) begin
          if (req_valid_q || rsp_pending_q) begin
            dmistat_d = 2'd3;
          end else if ((dmistat_q == 2'd0) &&
                       ((dr_q[1:0] == 2'd1) || (dr_q[1:0] == 2'd2))) begin
            req_d       = dmi_req_t'(dr_q);
            req_valid_d = 1'b1;
            last_addr_d = dr_q[DrW-1:DataW+OpW];
          end
        end
      end
    end

    if (state_q == TapTlr) begin
      ir_d = IrIdcode;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
      tck_prev_q    <= 1'b0;
      state_q       <= TapTlr;
      ir_q          <= IrIdcode;
      ir_shift_q    <= '0;
      dr_q          <= '0;
      dmistat_q     <= 2'd0;
      last_addr_q   <= '0;
      last_data_q   <= '0;
      req_q         <= '0;
      req_valid_q   <= 1'b0;
      rsp_pending_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SyncStages; i++) begin
        sync_q[i] <= sync_d[i];
      end
      tck_prev_q    <= tck_prev_d;
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_shift_q    <= ir_shift_d;
      dr_q          <= dr_d;
      dmistat_q     <= dmistat_d;
      last_addr_q   <= last_addr_d;
      last_data_q   <= last_data_d;
      req_q         <= req_d;
      req_valid_q   <= req_valid_d;
      rsp_pending_q <= rsp_pending_d;
      tdo_q         <= tdo_d;
      tdo_oe_q      <= tdo_oe_d;
    end
  end

  assign jtag_tdo_o      = tdo_q;
  assign jtag_tdo_oe_o   = tdo_oe_q;
  assign dmi_req_o       = req_q;
  assign dmi_req_valid_o = req_valid_q;
  assign dmi_rsp_ready_o = rsp_pending_q;

endmodule

// File: tb/tb_jtag_dmi_responder.sv
// Directed bench for jtag_dmi_responder: TCK is bit-banged slowly on the
// pins, DMI handshakes are driven by hand, expectations are constants.

module tb_jtag_dmi_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni;
  logic        jtag_tdo_o, jtag_tdo_oe_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [40:0] dmi_req_o;
  logic        dmi_rsp_valid_i, dmi_rsp_ready_o;
  logic [33:0] dmi_rsp_i;

  int checks = 0;
  int errors = 0;

  localparam logic [40:0] IdExp    = 41'h0_1C5E_5DB3;
  // {7'h04, 32'hDEADBEEF, 2'd2} = 41'h13_7AB6_FBBE
  localparam logic [40:0] ReqWr    = {7'h04, 32'hDEAD_BEEF, 2'd2};
  localparam logic [40:0] ReqRd4   = {7'h04, 32'h0, 2'd1};
  localparam logic [40:0] ReqRd5   = {7'h05, 32'h0, 2'd1};
  localparam logic [40:0] ReqWr6   = {7'h06, 32'h0000_00AA, 2'd2};
  localparam logic [40:0] ReqRd7   = {7'h07, 32'h0, 2'd1};
  localparam logic [40:0] ReqRd8   = {7'h08, 32'h0, 2'd1};
  localparam logic [40:0] ReqRd9   = {7'h09, 32'h0, 2'd1};

  always #5 clk_i = ~clk_i;

  jtag_dmi_responder dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .jtag_tck_i     (jtag_tck_i),
    .jtag_tms_i     (jtag_tms_i),
    .jtag_tdi_i     (jtag_tdi_i),
    .jtag_trst_ni   (jtag_trst_ni),
    .jtag_tdo_o     (jtag_tdo_o),
    .jtag_tdo_oe_o  (jtag_tdo_oe_o),
    .dmi_req_valid_o(dmi_req_valid_o),
    .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_o      (dmi_req_o),
    .dmi_rsp_valid_i(dmi_rsp_valid_i),
    .dmi_rsp_ready_o(dmi_rsp_ready_o),
    .dmi_rsp_i      (dmi_rsp_i)
  );

  task automatic check(input string tag, input logic [40:0] obs, input logic [40:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One slow TCK period; returns on a clk_i falling edge with TCK low
  task automatic tck(input logic tms, input logic tdi);
    jtag_tms_i = tms;
    jtag_tdi_i = tdi;
    repeat (4) @(negedge clk_i);
    jtag_tck_i = 1'b1;
    repeat (4) @(negedge clk_i);
    jtag_tck_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  // Idle -> Shift-DR, n bits LSB first, -> Update-DR -> Idle
  task automatic scan_dr(input logic [40:0] din, input int n, output logic [40:0] dout);
    dout = '0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag_tdo_o;
      tck(i == n - 1, din[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // Idle -> Shift-IR, 5 bits -> Update-IR -> Idle
  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] irout);
    irout = '0;
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      irout[i] = jtag_tdo_o;
      tck(i == 4, ir[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic handshake();
    dmi_req_ready_i = 1'b1;
    @(negedge clk_i);
    dmi_req_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_rsp_i       = {data, resp};
    dmi_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    dmi_rsp_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdo"},       41'(jtag_tdo_o), 41'd0);
    check({tag, "_tdo_oe"},    41'(jtag_tdo_oe_o), 41'd0);
    check({tag, "_req_valid"}, 41'(dmi_req_valid_o), 41'd0);
    check({tag, "_req"},       dmi_req_o, 41'd0);
    check({tag, "_rsp_ready"}, 41'(dmi_rsp_ready_o), 41'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [40:0] d;
    logic [4:0]  irc;

    rst_ni          = 1'b0;
    jtag_tck_i      = 1'b0;
    jtag_tms_i      = 1'b0;
    jtag_tdi_i      = 1'b0;
    jtag_trst_ni    = 1'b1;
    dmi_req_ready_i = 1'b0;
    dmi_rsp_valid_i = 1'b0;
    dmi_rsp_i       = '0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("por");
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    // IDCODE selected out of reset
    tck(1'b0, 1'b0);
    scan_dr(41'd0, 32, d);
    check("idcode", d, IdExp);

    // DTMCS read, IR capture pattern
    scan_ir(5'h10, irc);
    check("ir_capture", 41'(irc), 41'd1);
    scan_dr(41'd0, 32, d);
    check("dtmcs_idle", d, 41'h0000_1071);

    // DMI write held by ready low for 10 cycles
    scan_ir(5'h11, irc);
    scan_dr(ReqWr, 41, d);
    check("dmi_cap_first", d, 41'd0);
    for (int i = 0; i < 10; i++) begin
      check("wr_hold_valid", 41'(dmi_req_valid_o), 41'd1);
      check("wr_hold_req", dmi_req_o, ReqWr);
      check("wr_hold_rsp_ready", 41'(dmi_rsp_ready_o), 41'd0);
      @(negedge clk_i);
    end
    handshake();
    check("wr_valid_drop", 41'(dmi_req_valid_o), 41'd0);
    check("wr_rsp_ready", 41'(dmi_rsp_ready_o), 41'd1);
    @(negedge clk_i);
    check("wr_valid_stays_low", 41'(dmi_req_valid_o), 41'd0);
    respond(32'h0, 2'd0);
    check("wr_rsp_ready_drop", 41'(dmi_rsp_ready_o), 41'd0);

    // Read, response data visible on next capture
    scan_dr(ReqRd4, 41, d);
    check("rd_valid", 41'(dmi_req_valid_o), 41'd1);
    check("rd_req", dmi_req_o, ReqRd4);
    handshake();
    respond(32'h1234_5678, 2'd0);
    scan_dr(41'd0, 41, d);
    check("rd_capture", d, {7'h04, 32'h1234_5678, 2'b00});

    // Second access while busy: no new request, sticky busy status
    scan_dr(ReqRd5, 41, d);
    check("busy_first_valid", 41'(dmi_req_valid_o), 41'd1);
    scan_dr(ReqWr6, 41, d);
    check("busy_cap_before", d, {7'h05, 32'h1234_5678, 2'd0});
    check("busy_req_kept", dmi_req_o, ReqRd5);
    check("busy_valid_kept", 41'(dmi_req_valid_o), 41'd1);
    scan_dr(41'd0, 41, d);
    check("busy_cap_op3", d, {7'h05, 32'h1234_5678, 2'd3});
    handshake();
    respond(32'hCAFE_F00D, 2'd0);
    scan_ir(5'h10, irc);
    scan_dr(41'h0_0001_0000, 32, d);
    check("dtmcs_busy", d, 41'h0000_1C71);
    scan_ir(5'h11, irc);
    scan_dr(41'd0, 41, d);
    check("busy_cleared", d, {7'h05, 32'hCAFE_F00D, 2'd0});

    // Error response sets dmistat 2 and blocks further requests
    scan_dr(ReqRd7, 41, d);
    check("err_req", dmi_req_o, ReqRd7);
    handshake();
    respond(32'h0BAD_0BAD, 2'd2);
    scan_dr(ReqRd8, 41, d);
    check("err_cap_op2", d, {7'h07, 32'h0BAD_0BAD, 2'd2});
    check("err_blocks_req", 41'(dmi_req_valid_o), 41'd0);
    scan_ir(5'h10, irc);
    scan_dr(41'h0_0002_0000, 32, d);
    check("dtmcs_err", d, 41'h0000_1871);
    scan_ir(5'h11, irc);
    scan_dr(ReqRd9, 41, d);
    check("hardreset_cap", d, {7'h07, 32'h0BAD_0BAD, 2'd0});
    check("post_clear_valid", 41'(dmi_req_valid_o), 41'd1);
    check("post_clear_req", dmi_req_o, ReqRd9);

    // BYPASS: TDO is TDI one TCK later, leading captured 0
    scan_ir(5'h0A, irc);
    scan_dr(41'h0_0000_00B2, 8, d);
    check("bypass", d, 41'h0_0000_0064);

    // Five TMS-high edges return to Test-Logic-Reset (IDCODE)
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    scan_dr(41'd0, 32, d);
    check("tms_reset_idcode", d, IdExp);

    // rst_ni mid Shift-DR with a request still outstanding
    scan_ir(5'h0A, irc);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b1);
    tck(1'b0, 1'b1);
    check("shift_tdo", 41'(jtag_tdo_o), 41'd1);
    check("shift_tdo_oe", 41'(jtag_tdo_oe_o), 41'd1);
    check("shift_req_pending", 41'(dmi_req_valid_o), 41'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    rst_ni     = 1'b1;
    jtag_tdi_i = 1'b0;
    repeat (4) @(negedge clk_i);
    tck(1'b0, 1'b0);
    scan_dr(41'd0, 32, d);
    check("post_rst_idcode", d, IdExp);
    check("post_rst_valid", 41'(dmi_req_valid_o), 41'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
